// File: rtl/missile_hit_resolver_pkg.sv
// Shared game constants and types for the missile/enemy collision logic.
// Coordinates are 10-bit screen positions; overlap math widens to 11 bits.
package missile_hit_resolver_pkg;

  localparam int NUM_ENEMIES = 24;
  localparam int ENEMY_SIZE  = 16;
  localparam int MISSILE_W   = 2;
  localparam int MISSILE_H   = 8;
  localparam int IDX_W       = 5;
  localparam int KILL_W      = 5;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } resolver_state_t;

  // One-axis box overlap; the extra bit keeps edges near 1023 from wrapping.
  function automatic logic span_overlap(input coord_t m, input coord_t e, input logic [10:0] m_len);
    logic [10:0] m_end;
    logic [10:0] e_end;
    e_end = {1'b0, e} + 11'(ENEMY_SIZE - 1);
    m_end = {1'b0, m} + m_len - 11'd1;
    return ({1'b0, m} <= e_end) && ({1'b0, e} <= m_end);
  endfunction

endpackage

// File: rtl/missile_hit_resolver_tick.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-cycle tick on each rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/missile_hit_resolver.sv
// Per-frame scan of all enemy slots against the player missile; flags the
// lowest-index overlapping live enemy, retires the missile and counts kills.
module missile_hit_resolver
  import missile_hit_resolver_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   frame_clk,
  input  logic   missile_active,
  input  coord_t missile_posX,
  input  coord_t missile_posY,
  input  coord_t enemy_posX [0:NUM_ENEMIES-1],
  input  coord_t enemy_posY [0:NUM_ENEMIES-1],
  input  logic   enemy_present [0:NUM_ENEMIES-1],
  output logic   enemy_missile_collision [0:NUM_ENEMIES-1],
  output logic   missile_hit,
  output logic [KILL_W-1:0] kill_count,
  output logic   all_destroyed,
  output logic   busy
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [KILL_W-1:0] KILL_MAX = KILL_W'(NUM_ENEMIES);

  resolver_state_t          state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     snap_active_q, snap_active_d;
  coord_t                   snap_x_q, snap_x_d;
  coord_t                   snap_y_q, snap_y_d;
  logic [NUM_ENEMIES-1:0]   coll_q, coll_d;
  logic                     hit_q, hit_d;
  logic [KILL_W-1:0]        kill_q, kill_d;
  logic                     all_q, all_d;

  logic   tick;
  coord_t cur_ex, cur_ey;
  logic   cur_present;
  logic   slot_hit;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Enemy state is read live; it only changes on frame_clk, so it is stable during a scan.
  always_comb begin
    cur_ex      = enemy_posX[idx_q];
    cur_ey      = enemy_posY[idx_q];
    cur_present = enemy_present[idx_q];
    slot_hit    = snap_active_q && cur_present &&
                  span_overlap(snap_x_q, cur_ex, 11'(MISSILE_W)) &&
                  span_overlap(snap_y_q, cur_ey, 11'(MISSILE_H));
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_active_d = snap_active_q;
    snap_x_d      = snap_x_q;
    snap_y_d      = snap_y_q;
    coll_d        = coll_q;
    hit_d         = 1'b0;
    kill_d        = kill_q;
    all_d         = (kill_q == KILL_MAX);

    case (state_q)
      IDLE: begin
        // Vector has already been sampled by the enemy block on the frame edge.
        if (tick) begin
          coll_d        = '0;
          snap_active_d = missile_active;
          snap_x_d      = missile_posX;
          snap_y_d      = missile_posY;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (slot_hit) begin
          coll_d[idx_q] = 1'b1;
          hit_d         = 1'b1;
          if (kill_q != KILL_MAX) begin
            kill_d = kill_q + KILL_W'(1);
          end
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_active_q <= 1'b0;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      coll_q        <= '0;
      hit_q         <= 1'b0;
      kill_q        <= '0;
      all_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_active_q <= snap_active_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      coll_q        <= coll_d;
      hit_q         <= hit_d;
      kill_q        <= kill_d;
      all_q         <= all_d;
    end
  end

  for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_coll_out
    assign enemy_missile_collision[gi] = coll_q[gi];
  end

  assign missile_hit   = hit_q;
  assign kill_count    = kill_q;
  assign all_destroyed = all_q;
  assign busy          = (state_q == SCAN) || (state_q == DONE);

endmodule

// File: tb/tb_missile_hit_resolver.sv
// Scoreboard bench: each frame pushes its expected outcome, a monitor checks
// the DUT when a scan ends (busy falls).
module tb_missile_hit_resolver;
  import missile_hit_resolver_pkg::*;

  logic   Clk;
  logic   Reset;
  logic   frame_clk;
  logic   missile_active;
  coord_t missile_posX;
  coord_t missile_posY;
  coord_t enemy_posX [0:NUM_ENEMIES-1];
  coord_t enemy_posY [0:NUM_ENEMIES-1];
  logic   enemy_present [0:NUM_ENEMIES-1];
  logic   enemy_missile_collision [0:NUM_ENEMIES-1];
  logic   missile_hit;
  logic [KILL_W-1:0] kill_count;
  logic   all_destroyed;
  logic   busy;

  missile_hit_resolver dut (
    .Clk                     (Clk),
    .Reset                   (Reset),
    .frame_clk               (frame_clk),
    .missile_active          (missile_active),
    .missile_posX            (missile_posX),
    .missile_posY            (missile_posY),
    .enemy_posX              (enemy_posX),
    .enemy_posY              (enemy_posY),
    .enemy_present           (enemy_present),
    .enemy_missile_collision (enemy_missile_collision),
    .missile_hit             (missile_hit),
    .kill_count              (kill_count),
    .all_destroyed           (all_destroyed),
    .busy                    (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int win;
    int kills;
    int all;
    int coll;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;
  int   frames_done;
  bit   mon_en;
  int   model_kills;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic int coll_vec();
    int v;
    v = 0;
    for (int i = 0; i < NUM_ENEMIES; i++) if (enemy_missile_collision[i] === 1'b1) v |= (1 << i);
    return v;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  // Reference: boxes [m, m+w-1] and [e, e+size-1] intersect on both axes.
  function automatic bit overlaps(input int i, input int mx, input int my);
    int ex, ey;
    ex = int'(enemy_posX[i]);
    ey = int'(enemy_posY[i]);
    return (mx <= ex + ENEMY_SIZE - 1) && (ex <= mx + MISSILE_W - 1) &&
           (my <= ey + ENEMY_SIZE - 1) && (ey <= my + MISSILE_H - 1);
  endfunction

  task automatic set_grid();
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_posX[i]    = coord_t'(43 + 18 * (i % 8));
      enemy_posY[i]    = coord_t'(48 + 24 * (i / 8));
      enemy_present[i] = 1'b1;
    end
  endtask

  task automatic run_frame(input bit act, input int mx, input int my, input bit retick);
    exp_t e;
    int   start;
    e.win = -1;
    if (act) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        if (enemy_present[i] && overlaps(i, mx, my)) begin
          e.win = i;
          break;
        end
      end
    end
    e.coll = 0;
    if (e.win >= 0) begin
      e.coll = 1 << e.win;
      if (model_kills < NUM_ENEMIES) model_kills++;
    end
    e.kills = model_kills;
    e.all   = (model_kills == NUM_ENEMIES) ? 1 : 0;
    e.len   = (e.win >= 0) ? e.win + 2 : NUM_ENEMIES + 1;
    exp_q.push_back(e);

    missile_active = act;
    missile_posX   = coord_t'(mx);
    missile_posY   = coord_t'(my);
    start = frames_done;
    @(posedge Clk);
    #2 frame_clk = 1'b1;
    repeat (5) @(posedge Clk);
    // Snapshot has been taken; scrambling the live inputs must not matter.
    #1;
    missile_active = 1'($urandom);
    missile_posX   = coord_t'($urandom);
    missile_posY   = coord_t'($urandom);
    if (retick) begin
      frame_clk = 1'b0;
      repeat (2) @(posedge Clk);
      #1 frame_clk = 1'b1;
    end
    for (int c = 0; c < 100 && frames_done == start; c++) @(posedge Clk);
    check("frame_timeout", frames_done - start, 1);
    #1 frame_clk = 1'b0;
    if (e.win >= 0) enemy_present[e.win] = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  initial begin : monitor
    bit   in_scan;
    int   cnt;
    int   pulses;
    int   hit_at;
    exp_t e;
    in_scan = 1'b0;
    cnt     = 0;
    pulses  = 0;
    hit_at  = 0;
    forever begin
      @(negedge Clk);
      if (!mon_en || Reset) begin
        in_scan = 1'b0;
      end else begin
        if (!in_scan && missile_hit) check("stray_hit", 1, 0);
        if (busy && !in_scan) begin
          in_scan = 1'b1;
          cnt     = 0;
          pulses  = 0;
          hit_at  = 0;
          check("clear_on_tick", coll_vec(), 0);
        end
        if (in_scan) begin
          if (busy) begin
            cnt++;
            if (missile_hit) begin
              pulses++;
              hit_at = cnt;
            end
          end else begin
            in_scan = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_scan", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("busy_len", cnt, e.len);
              check("hit_pulses", pulses, (e.win >= 0) ? 1 : 0);
              check("hit_latency", hit_at, (e.win >= 0) ? e.win + 2 : 0);
              check("collision", coll_vec(), e.coll);
              check("kill_count", int'(kill_count), e.kills);
              check("all_destroyed", int'(all_destroyed), e.all);
              $display("frame %0d: win=%0d kills=%0d busy_cycles=%0d", frames_done, e.win, e.kills, cnt);
              frames_done++;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int cnt;
    int quiet;
    int t, mx, my;
    errors = 0; checks = 0; frames_done = 0; mon_en = 1'b0; model_kills = 0;
    Reset = 1'b1; frame_clk = 1'b0; missile_active = 1'b0;
    missile_posX = '0; missile_posY = '0;
    set_grid();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", int'(busy), 0);
    check("rst_hit", int'(missile_hit), 0);
    check("rst_kill", int'(kill_count), 0);
    check("rst_all", int'(all_destroyed), 0);
    check("rst_coll", coll_vec(), 0);
    Reset = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge Clk);

    run_frame(1'b1, 50, 50, 1'b0);      // direct hit slot 0
    run_frame(1'b1, 300, 300, 1'b1);    // miss, with a dropped mid-scan tick
    repeat (30) @(posedge Clk);
    run_frame(1'b0, 79, 48, 1'b0);      // inactive missile on enemy 2

    enemy_present[0] = 1'b1;            // priority: enemy 1 moved to overlap too
    enemy_posX[1] = coord_t'(52);
    run_frame(1'b1, 57, 60, 1'b0);
    run_frame(1'b1, 57, 60, 1'b0);
    enemy_posX[1] = coord_t'(61);
    run_frame(1'b1, 50, 50, 1'b0);      // dead enemy 0 at missile

    set_grid();                          // far-edge geometry
    enemy_posX[5] = coord_t'(1015);
    enemy_posY[5] = coord_t'(1000);
    run_frame(1'b1, 1023, 1003, 1'b0);

    set_grid();
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NUM_ENEMIES; i++) enemy_present[i] = ($urandom_range(0, 3) != 0);
      t  = $urandom_range(0, NUM_ENEMIES - 1);
      mx = clamp(int'(enemy_posX[t]) + int'($urandom_range(0, 22)) - 4);
      my = clamp(int'(enemy_posY[t]) + int'($urandom_range(0, 30)) - 10);
      run_frame($urandom_range(0, 5) != 0, mx, my, 1'b0);
    end

    set_grid();                          // saturation
    for (int i = 0; i < NUM_ENEMIES; i++)
      run_frame(1'b1, int'(enemy_posX[i]) + 4, int'(enemy_posY[i]) + 4, 1'b0);
    run_frame(1'b1, int'(enemy_posX[3]) + 4, int'(enemy_posY[3]) + 4, 1'b0);

    mon_en = 1'b0;                       // reset while scanning slot 10
    set_grid();
    missile_active = 1'b1;
    missile_posX = coord_t'(int'(enemy_posX[12]) + 4);
    missile_posY = coord_t'(int'(enemy_posY[12]) + 4);
    @(posedge Clk);
    #2 frame_clk = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 11; c++) begin
      @(negedge Clk);
      if (busy) cnt++;
    end
    check("reach_idx10", cnt, 11);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_coll", coll_vec(), 0);
    check("mid_rst_kill", int'(kill_count), 0);
    check("mid_rst_hit", int'(missile_hit), 0);
    check("mid_rst_all", int'(all_destroyed), 0);
    Reset = 1'b0;
    model_kills = 0;
    quiet = 0;
    repeat (30) begin
      @(negedge Clk);
      if (missile_hit || busy) quiet++;
    end
    check("post_rst_quiet", quiet, 0);
    mon_en = 1'b1;
    run_frame(1'b1, int'(enemy_posX[12]) + 4, int'(enemy_posY[12]) + 4, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
